onehot_mux_sweep_checker: RTL and testbench



---
 rtl/onehot_mux_sweep_checker.sv | 186 ++++++++++++++++++
 tb/tb_onehot_mux_sweep_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_mux_sweep_checker.sv
// Sequencer that walks every one-hot select of an external N_CH-way mux over NUM_PAT
// data patterns, compares the mux output bit-exactly and records the first failure.
module onehot_mux_sweep_checker #(
  parameter int           N_CH     = 4,
  parameter int           W        = 8,
  parameter int           MUX_LAT  = 0,
  parameter int           NUM_PAT  = 4,
  parameter logic [W-1:0] BASE     = 8'h11,
  parameter logic [W-1:0] STEP     = 8'h22,
  parameter bit           DISTINCT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [N_CH-1:0]   sel_o,
  output logic [N_CH*W-1:0] data_o,
  input  logic [W-1:0]      mux_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [4:0]        fail_ch,
  output logic [7:0]        fail_pat
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] CH_LAST   = 5'(N_CH - 1);
  localparam logic [7:0] PAT_LAST  = 8'(NUM_PAT - 1);
  localparam logic [2:0] WAIT_LAST = 3'((MUX_LAT > 0) ? (MUX_LAT - 1) : 0);
  localparam bit         HAS_WAIT  = (MUX_LAT > 0);

  state_t              state_q;
  logic [4:0]          ch_q;
  logic [7:0]          pat_q;
  logic [2:0]          wait_q;
  logic                first_fail_q;
  logic [N_CH-1:0]     sel_q;
  logic [N_CH*W-1:0]   data_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [15:0]         err_q;
  logic [4:0]          fail_ch_q;
  logic [7:0]          fail_pat_q;

  logic [W-1:0]        exp_s;
  logic                mismatch_s;
  logic [15:0]         err_d;
  logic                last_ch_s;
  logic [4:0]          ch_d;
  logic [7:0]          pat_d;

  // Pattern value wraps modulo 2^W; no saturation on data.
  function automatic logic [W-1:0] pat_val(input logic [7:0] p);
    pat_val = BASE + (W'(p) * STEP);
  endfunction

  function automatic logic [N_CH*W-1:0] pat_data(input logic [7:0] p);
    logic [W-1:0] v;
    v = pat_val(p);
    pat_data = {(N_CH*W){1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      pat_data[k*W +: W] = DISTINCT ? (v + W'(k)) : v;
    end
  endfunction

  function automatic logic [N_CH-1:0] one_hot(input logic [4:0] c);
    one_hot = {N_CH{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      one_hot[k] = (c == 5'(k));
    end
  endfunction

  // Expected value, saturating error count and next (channel, pattern) position.
  always_comb begin
    exp_s      = pat_val(pat_q) + (DISTINCT ? W'(ch_q) : {W{1'b0}});
    mismatch_s = (mux_i != exp_s);
    if (mismatch_s && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
    last_ch_s = (ch_q == CH_LAST);
    ch_d      = last_ch_s ? 5'd0 : (ch_q + 5'd1);
    pat_d     = last_ch_s ? (pat_q + 8'd1) : pat_q;
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_q         <= 5'd0;
      pat_q        <= 8'd0;
      wait_q       <= 3'd0;
      first_fail_q <= 1'b0;
      sel_q        <= {N_CH{1'b0}};
      data_q       <= {(N_CH*W){1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 16'd0;
      fail_ch_q    <= 5'd0;
      fail_pat_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_DRIVE;
            ch_q         <= 5'd0;
            pat_q        <= 8'd0;
            wait_q       <= 3'd0;
            first_fail_q <= 1'b0;
            sel_q        <= one_hot(5'd0);
            data_q       <= pat_data(8'd0);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 16'd0;
            fail_ch_q    <= 5'd0;
            fail_pat_q   <= 8'd0;
          end
        end
        S_DRIVE: begin
          wait_q  <= 3'd0;
          state_q <= HAS_WAIT ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch_s && !first_fail_q) begin
            first_fail_q <= 1'b1;
            fail_ch_q    <= ch_q;
            fail_pat_q   <= pat_q;
          end
          if (last_ch_s && (pat_q == PAT_LAST)) begin
            state_q <= S_DONE;
            ch_q    <= 5'd0;
            pat_q   <= 8'd0;
            sel_q   <= {N_CH{1'b0}};
            data_q  <= {(N_CH*W){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end else begin
            state_q <= S_DRIVE;
            ch_q    <= ch_d;
            pat_q   <= pat_d;
            sel_q   <= one_hot(ch_d);
            data_q  <= pat_data(pat_d);
          end
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= {N_CH{1'b0}};
          data_q  <= {(N_CH*W){1'b0}};
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign data_o    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_ch   = fail_ch_q;
  assign fail_pat  = fail_pat_q;

endmodule

// File: tb/tb_onehot_mux_sweep_checker.sv
// Directed bench: three checker instances (defaults, all-same data, latency 2 with
// wrapping patterns) each driving a behavioural mux model selected per scenario.
module tb_onehot_mux_sweep_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic [3:0]  sel_v   [3];
  logic [31:0] data_v  [3];
  logic [7:0]  mux_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [15:0] err_v   [3];
  logic [4:0]  fch_v   [3];
  logic [7:0]  fpat_v  [3];

  int          mode_a;
  int          mode_c;
  logic [7:0]  st1, st2;

  int          checks   = 0;
  int          failures = 0;
  int          n_busy;
  bit          hot_ok;
  logic [3:0]  sel_h  [0:23];
  logic [31:0] data_h [0:23];
  logic        done_h1;
  logic [15:0] err_h1;

  always #5 clk = ~clk;

  onehot_mux_sweep_checker u_a (
    .clock(clk), .reset(rst), .start(start_v[0]), .sel_o(sel_v[0]), .data_o(data_v[0]),
    .mux_i(mux_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .fail_ch(fch_v[0]), .fail_pat(fpat_v[0])
  );

  onehot_mux_sweep_checker #(.DISTINCT(1'b0)) u_b (
    .clock(clk), .reset(rst), .start(start_v[1]), .sel_o(sel_v[1]), .data_o(data_v[1]),
    .mux_i(mux_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .fail_ch(fch_v[1]), .fail_pat(fpat_v[1])
  );

  onehot_mux_sweep_checker #(.MUX_LAT(2), .BASE(8'hFE), .STEP(8'h01)) u_c (
    .clock(clk), .reset(rst), .start(start_v[2]), .sel_o(sel_v[2]), .data_o(data_v[2]),
    .mux_i(mux_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .fail_ch(fch_v[2]), .fail_pat(fpat_v[2])
  );

  function automatic logic [7:0] pick(input logic [3:0] s, input logic [31:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) r = r | d[k*8 +: 8];
    end
    return r;
  endfunction

  // Mux models: ideal, stuck at zero, always channel 0, two-stage registered.
  always_comb begin
    if (mode_a == 0)      mux_v[0] = pick(sel_v[0], data_v[0]);
    else if (mode_a == 1) mux_v[0] = 8'h00;
    else                  mux_v[0] = data_v[0][7:0];
    mux_v[1] = data_v[1][7:0];
    mux_v[2] = (mode_c == 1) ? pick(sel_v[2], data_v[2]) : st2;
  end

  always_ff @(posedge clk) begin
    st1 <= pick(sel_v[2], data_v[2]);
    st2 <= st1;
  end

  task automatic sweep(input int idx, input int poke);
    int steps;
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    n_busy = 0;
    hot_ok = 1'b1;
    steps  = 0;
    done_h1 = 1'bx;
    err_h1  = 16'hxxxx;
    while (done_v[idx] !== 1'b1 && steps < 200) begin
      if (busy_v[idx] === 1'b1) n_busy++;
      if (n_busy < 24) begin
        sel_h[n_busy]  = sel_v[idx];
        data_h[n_busy] = data_v[idx];
      end
      if (steps == 0) begin
        done_h1 = done_v[idx];
        err_h1  = err_v[idx];
      end
      if (!$onehot0(sel_v[idx])) hot_ok = 1'b0;
      start_v[idx] = (poke > 0 && n_busy == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
      steps++;
    end
    start_v[idx] = 1'b0;
    checks++;
    if (done_v[idx] !== 1'b1) begin
      failures++;
      $display("FAIL sweep_timeout inst=%0d done=%b exp=1", idx, done_v[idx]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    mode_a = 0;
    mode_c = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sel_v[i], data_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fch_v[i], fpat_v[i]} !== 70'd0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d sel=%h data=%h busy=%b done=%b pass=%b err=%h exp all 0",
                 i, sel_v[i], data_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    mode_a = 0;
    sweep(0, 0);
    checks++; if (n_busy !== 32) begin failures++; $display("FAIL ideal_busy_cycles got=%0d exp=32", n_busy); end
    checks++; if (sel_h[1] !== 4'b0001) begin failures++; $display("FAIL ideal_first_sel got=%b exp=0001", sel_h[1]); end
    checks++; if (data_h[1] !== 32'h14131211) begin failures++; $display("FAIL ideal_first_data got=%h exp=14131211", data_h[1]); end
    checks++; if (sel_h[3] !== 4'b0010) begin failures++; $display("FAIL ideal_step1_sel got=%b exp=0010", sel_h[3]); end
    checks++; if (data_h[9] !== 32'h36353433) begin failures++; $display("FAIL ideal_pat1_data got=%h exp=36353433", data_h[9]); end
    checks++; if (hot_ok !== 1'b1) begin failures++; $display("FAIL ideal_onehot got=%b exp=1", hot_ok); end
    checks++; if ({pass_v[0], err_v[0]} !== {1'b1, 16'd0}) begin failures++; $display("FAIL ideal_result pass=%b err=%0d exp pass=1 err=0", pass_v[0], err_v[0]); end
    checks++; if ({sel_v[0], data_v[0], busy_v[0]} !== 37'd0) begin failures++; $display("FAIL done_idle_outputs sel=%b data=%h busy=%b exp 0", sel_v[0], data_v[0], busy_v[0]); end
  endtask

  task automatic test_zero;
    mode_a = 1;
    sweep(0, 0);
    checks++; if (n_busy !== 32) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=32", n_busy); end
    checks++; if (err_v[0] !== 16'd16) begin failures++; $display("FAIL zero_err got=%0d exp=16", err_v[0]); end
    checks++; if ({pass_v[0], fch_v[0], fpat_v[0]} !== 14'd0) begin failures++; $display("FAIL zero_fail_info pass=%b ch=%0d pat=%0d exp 0/0/0", pass_v[0], fch_v[0], fpat_v[0]); end
  endtask

  task automatic test_ch0_distinct;
    mode_a = 2;
    sweep(0, 0);
    checks++; if (err_v[0] !== 16'd12) begin failures++; $display("FAIL ch0_err got=%0d exp=12", err_v[0]); end
    checks++; if (fch_v[0] !== 5'd1) begin failures++; $display("FAIL ch0_fail_ch got=%0d exp=1", fch_v[0]); end
    checks++; if (fpat_v[0] !== 8'd0) begin failures++; $display("FAIL ch0_fail_pat got=%0d exp=0", fpat_v[0]); end
    checks++; if (pass_v[0] !== 1'b0) begin failures++; $display("FAIL ch0_pass got=%b exp=0", pass_v[0]); end
  endtask

  task automatic test_ch0_same;
    sweep(1, 0);
    checks++; if (data_h[1] !== 32'h11111111) begin failures++; $display("FAIL same_data got=%h exp=11111111", data_h[1]); end
    checks++; if ({pass_v[1], err_v[1]} !== {1'b1, 16'd0}) begin failures++; $display("FAIL same_result pass=%b err=%0d exp pass=1 err=0", pass_v[1], err_v[1]); end
  endtask

  task automatic test_latency_reg;
    mode_c = 0;
    sweep(2, 0);
    checks++; if (n_busy !== 64) begin failures++; $display("FAIL lat_busy_cycles got=%0d exp=64", n_busy); end
    checks++; if (data_h[1] !== 32'h0100FFFE) begin failures++; $display("FAIL lat_wrap_data got=%h exp=0100FFFE", data_h[1]); end
    checks++; if (data_h[17] !== 32'h020100FF) begin failures++; $display("FAIL lat_pat1_data got=%h exp=020100FF", data_h[17]); end
    checks++; if ({sel_h[1], sel_h[4], sel_h[5], sel_h[8], sel_h[9]} !== 20'b0001_0001_0010_0010_0100) begin
      failures++; $display("FAIL lat_sel_hold got=%b %b %b %b %b exp 0001 0001 0010 0010 0100", sel_h[1], sel_h[4], sel_h[5], sel_h[8], sel_h[9]);
    end
    checks++; if ({pass_v[2], err_v[2]} !== {1'b1, 16'd0}) begin failures++; $display("FAIL lat_reg_result pass=%b err=%0d exp pass=1 err=0", pass_v[2], err_v[2]); end
  endtask

  task automatic test_latency_comb;
    mode_c = 1;
    sweep(2, 0);
    checks++; if (n_busy !== 64) begin failures++; $display("FAIL latc_busy_cycles got=%0d exp=64", n_busy); end
    checks++; if ({pass_v[2], err_v[2]} !== {1'b1, 16'd0}) begin failures++; $display("FAIL latc_result pass=%b err=%0d exp pass=1 err=0", pass_v[2], err_v[2]); end
  endtask

  task automatic test_start_busy;
    mode_a = 0;
    sweep(0, 5);
    checks++; if (n_busy !== 32) begin failures++; $display("FAIL busy_start_cycles got=%0d exp=32", n_busy); end
    checks++; if (pass_v[0] !== 1'b1) begin failures++; $display("FAIL busy_start_pass got=%b exp=1", pass_v[0]); end
  endtask

  task automatic test_reset_mid;
    mode_a = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if ({err_v[0], fch_v[0]} !== {16'd3, 5'd1}) begin failures++; $display("FAIL mid_pre_reset err=%0d ch=%0d exp err=3 ch=1", err_v[0], fch_v[0]); end
    rst = 1'b1;
    #1;
    checks++;
    if ({sel_v[0], data_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fch_v[0], fpat_v[0]} !== 70'd0) begin
      failures++; $display("FAIL mid_reset_outputs sel=%b busy=%b err=%0d ch=%0d exp all 0", sel_v[0], busy_v[0], err_v[0], fch_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy_v[0], done_v[0], sel_v[0]} !== 6'd0) begin failures++; $display("FAIL mid_stays_idle busy=%b done=%b sel=%b exp 0", busy_v[0], done_v[0], sel_v[0]); end
  endtask

  task automatic test_back_to_back;
    mode_a = 2;
    sweep(0, 0);
    checks++; if (err_v[0] !== 16'd12) begin failures++; $display("FAIL b2b_first_err got=%0d exp=12", err_v[0]); end
    mode_a = 0;
    sweep(0, 0);
    checks++; if ({done_h1, err_h1} !== 17'd0) begin failures++; $display("FAIL b2b_restart_clear done=%b err=%0d exp 0/0", done_h1, err_h1); end
    checks++; if (n_busy !== 32) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=32", n_busy); end
    checks++; if ({pass_v[0], err_v[0], fch_v[0]} !== {1'b1, 16'd0, 5'd0}) begin failures++; $display("FAIL b2b_result pass=%b err=%0d ch=%0d exp 1/0/0", pass_v[0], err_v[0], fch_v[0]); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_zero();
    test_ch0_distinct();
    test_ch0_same();
    test_latency_reg();
    test_latency_comb();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
